// File: rtl/instr_imm_encoder_pkg.sv
// instr_imm_encoder_pkg: format codes, error codes and immediate range limits.
package instr_imm_encoder_pkg;
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_RANGE   = 2'b01;
    localparam logic [1:0] ERR_ALIGN   = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL = 2'b11;
    localparam int IS_MIN = -2048;
    localparam int IS_MAX = 2047;
    localparam int B_MIN  = -4096;
    localparam int B_MAX  = 4095;
    localparam int J_MIN  = -1048576;
    localparam int J_MAX  = 1048575;
endpackage

// File: rtl/instr_imm_encoder_imm_pack.sv
// instr_imm_encoder_imm_pack: packs an immediate and register fields into an RV32I word and checks legality.
module instr_imm_encoder_imm_pack
    import instr_imm_encoder_pkg::*;
(
    input  logic [2:0]  imm_src_i,
    input  logic [31:0] imm_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] inst_o,
    output logic        err_o,
    output logic [1:0]  code_o
);
    logic in_is, in_b, in_j, range_ok, align_ok;

    assign in_is = $signed(imm_i) >= IS_MIN && $signed(imm_i) <= IS_MAX;
    assign in_b  = $signed(imm_i) >= B_MIN  && $signed(imm_i) <= B_MAX;
    assign in_j  = $signed(imm_i) >= J_MIN  && $signed(imm_i) <= J_MAX;

    assign range_ok = (imm_src_i == IMM_I || imm_src_i == IMM_S) ? in_is :
                      (imm_src_i == IMM_B) ? in_b :
                      (imm_src_i == IMM_J) ? in_j : 1'b1;
    assign align_ok = (imm_src_i == IMM_B || imm_src_i == IMM_J) ? !imm_i[0] :
                      (imm_src_i == IMM_U) ? (imm_i[11:0] == 12'd0) : 1'b1;

    // Range outranks alignment when both fail
    assign code_o = (imm_src_i > IMM_U) ? ERR_ILLEGAL :
                    !range_ok ? ERR_RANGE :
                    !align_ok ? ERR_ALIGN : ERR_NONE;
    assign err_o  = code_o != ERR_NONE;

    always_comb begin
        inst_o = '0;
        case (imm_src_i)
            IMM_I: inst_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
            IMM_S: inst_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            IMM_B: inst_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11], opcode_i};
            IMM_J: inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            IMM_U: inst_o = {imm_i[31:12], rd_i, opcode_i};
            default: inst_o = '0;
        endcase
    end
endmodule

// File: rtl/instr_imm_encoder.sv
// instr_imm_encoder: two-stage pipeline emitting (address, encoded instruction) pairs for memory preload.
module instr_imm_encoder
    import instr_imm_encoder_pkg::*;
#(
    parameter int ERR_CNT_W  = 8,
    parameter int WORD_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            imm_src,
    input  logic [31:0]           imm,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    input  logic                  load_base,
    input  logic [31:0]           base_addr,
    input  logic                  clear_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_inst,
    output logic [31:0]           out_addr,
    output logic                  err_sticky,
    output logic [1:0]            err_code,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [WORD_CNT_W-1:0] word_count
);
    logic [31:0] pk_inst, base_al, addr_src;
    logic [1:0] pk_code;
    logic pk_err, s2_free, s1_move, accept, s2_enter, err_retire;
    logic s1_valid_q, s1_valid_d, s1_err_q, s1_err_d;
    logic [1:0] s1_code_q, s1_code_d;
    logic [31:0] s1_inst_q, s1_inst_d;
    logic out_valid_q, out_valid_d;
    logic [31:0] out_inst_q, out_inst_d, out_addr_q, out_addr_d, addr_q, addr_d;
    logic err_sticky_q, err_sticky_d;
    logic [1:0] err_code_q, err_code_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic [WORD_CNT_W-1:0] word_count_q, word_count_d;

    instr_imm_encoder_imm_pack u_pack (
        .imm_src_i(imm_src), .imm_i(imm), .opcode_i(opcode), .rd_i(rd),
        .rs1_i(rs1), .rs2_i(rs2), .funct3_i(funct3),
        .inst_o(pk_inst), .err_o(pk_err), .code_o(pk_code)
    );

    assign s2_free    = !out_valid_q || out_ready;
    assign s1_move    = s1_valid_q && (s1_err_q || s2_free);
    assign in_ready   = !s1_valid_q || s1_move;
    assign accept     = in_valid && in_ready;
    assign s2_enter   = s1_move && !s1_err_q;
    assign err_retire = s1_move && s1_err_q;
    assign base_al    = base_addr & ~32'h3;
    // A base load takes effect for a word entering S2 in the same cycle
    assign addr_src   = load_base ? base_al : addr_q;

    always_comb begin
        s1_valid_d   = accept || (s1_valid_q && !s1_move);
        s1_err_d     = accept ? pk_err : s1_err_q;
        s1_code_d    = accept ? pk_code : s1_code_q;
        s1_inst_d    = accept ? pk_inst : s1_inst_q;
        out_valid_d  = s2_enter || (out_valid_q && !out_ready);
        out_inst_d   = s2_enter ? s1_inst_q : out_inst_q;
        out_addr_d   = s2_enter ? addr_src : out_addr_q;
        addr_d       = s2_enter ? addr_src + 32'd4 : addr_src;
        err_sticky_d = err_retire || (err_sticky_q && !clear_err);
        err_code_d   = err_retire ? s1_code_q : clear_err ? ERR_NONE : err_code_q;
        err_count_d  = clear_err ? ERR_CNT_W'(err_retire) :
                       (err_retire && err_count_q != '1) ? err_count_q + ERR_CNT_W'(1) : err_count_q;
        word_count_d = word_count_q + WORD_CNT_W'(out_valid_q && out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_err_q     <= 1'b0;
            s1_code_q    <= ERR_NONE;
            s1_inst_q    <= '0;
            out_valid_q  <= 1'b0;
            out_inst_q   <= '0;
            out_addr_q   <= '0;
            addr_q       <= '0;
            err_sticky_q <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_err_q     <= s1_err_d;
            s1_code_q    <= s1_code_d;
            s1_inst_q    <= s1_inst_d;
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            out_addr_q   <= out_addr_d;
            addr_q       <= addr_d;
            err_sticky_q <= err_sticky_d;
            err_code_q   <= err_code_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_inst   = out_inst_q;
    assign out_addr   = out_addr_q;
    assign err_sticky = err_sticky_q;
    assign err_code   = err_code_q;
    assign err_count  = err_count_q;
    assign word_count = word_count_q;
endmodule

// File: tb/tb_instr_imm_encoder.sv
// tb_instr_imm_encoder: directed and randomized checks of the immediate encoder pipeline.
module tb_instr_imm_encoder;
    logic clk = 1'b0, rst = 1'b1;
    logic in_valid = 1'b0, in_ready;
    logic [2:0] imm_src = '0;
    logic [31:0] imm = '0;
    logic [6:0] opcode = '0;
    logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0] funct3 = '0;
    logic load_base = 1'b0, clear_err = 1'b0, out_ready = 1'b1;
    logic [31:0] base_addr = '0;
    logic out_valid, err_sticky;
    logic [31:0] out_inst, out_addr;
    logic [1:0] err_code;
    logic [7:0] err_count;
    logic [15:0] word_count;
    int n_cmp = 0, n_bad = 0;

    instr_imm_encoder #(.ERR_CNT_W(8), .WORD_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .imm_src(imm_src), .imm(imm), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .load_base(load_base), .base_addr(base_addr), .clear_err(clear_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
        .err_sticky(err_sticky), .err_code(err_code), .err_count(err_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Reference: {code, word} from the format rules using plain arithmetic
    function automatic logic [33:0] ref_enc(input logic [2:0] s, input logic [31:0] i, input logic [6:0] o,
                                            input logic [4:0] d, a, b, input logic [2:0] f);
        longint v, lim;
        logic [1:0] c;
        logic [31:0] w, im, dd, aa, bb, ff, oo;
        v = longint'($signed(i));
        im = i; dd = 32'(d); aa = 32'(a); bb = 32'(b); ff = 32'(f); oo = 32'(o);
        c = 2'd0; w = 32'd0;
        lim = (s <= 3'd1) ? 64'd2048 : (s == 3'd2) ? 64'd4096 : 64'd1048576;
        if (s > 3'd4) c = 2'd3;
        else if (s < 3'd4 && (v < -lim || v >= lim)) c = 2'd1;
        else if ((s == 3'd2 || s == 3'd3) && im % 2 != 0) c = 2'd2;
        else if (s == 3'd4 && im % 4096 != 0) c = 2'd2;
        case (s)
            3'd0: w = (im << 20) | (aa << 15) | (ff << 12) | (dd << 7) | oo;
            3'd1: w = ((im >> 5) << 25) | (bb << 20) | (aa << 15) | (ff << 12) | ((im & 31) << 7) | oo;
            3'd2: w = (((im >> 12) & 1) << 31) | (((im >> 5) & 63) << 25) | (bb << 20) | (aa << 15) | (ff << 12)
                      | (((im >> 1) & 15) << 8) | (((im >> 11) & 1) << 7) | oo;
            3'd3: w = (((im >> 20) & 1) << 31) | (((im >> 1) & 1023) << 21) | (((im >> 11) & 1) << 20)
                      | (((im >> 12) & 255) << 12) | (dd << 7) | oo;
            3'd4: w = (im & 32'hFFFFF000) | (dd << 7) | oo;
            default: w = 32'd0;
        endcase
        return {c, w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] s, input logic [31:0] i, input logic [6:0] o,
                       input logic [4:0] d, a, b, input logic [2:0] f);
        in_valid = 1'b1; imm_src = s; imm = i; opcode = o; rd = d; rs1 = a; rs2 = b; funct3 = f;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; load_base = 1'b0; clear_err = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_cmp++; if (out_inst !== 32'd0 || out_addr !== 32'd0) begin n_bad++; $display("FAIL reset_out_data got %h/%h exp 0/0", out_inst, out_addr); end
        n_cmp++; if ({err_sticky, err_code, err_count, word_count} !== 27'd0) begin n_bad++; $display("FAIL reset_err got %b %b %0d %0d exp 0", err_sticky, err_code, err_count, word_count); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_addi();
        do_reset();
        req(3'd0, 32'hFFFFFFFF, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL addi_early got %b exp 0", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_inst !== 32'hFFF10093) begin n_bad++; $display("FAIL addi_inst got %b %h exp 1 fff10093", out_valid, out_inst); end
        n_cmp++; if (out_addr !== 32'd0) begin n_bad++; $display("FAIL addi_addr got %h exp 0", out_addr); end
        tick();
        n_cmp++; if (word_count !== 16'd1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL addi_wc got %0d %b exp 1 0", word_count, out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req(3'd2, 32'hFFFFFFFC, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0);
        tick();
        req(3'd3, 32'd2048, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_inst !== 32'hFE208EE3 || out_addr !== 32'd0) begin n_bad++; $display("FAIL b2b_first got %b %h @%h exp 1 fe208ee3 @0", out_valid, out_inst, out_addr); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_inst !== 32'h0010006F || out_addr !== 32'd4) begin n_bad++; $display("FAIL b2b_second got %b %h @%h exp 1 0010006f @4", out_valid, out_inst, out_addr); end
    endtask

    task automatic test_errors();
        logic [33:0] r;
        int words;
        do_reset();
        r = ref_enc(3'd0, 32'd5, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0);
        req(3'd2, 32'd4096, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0);
        tick();
        req(3'd3, 32'd3, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0);
        tick();
        n_cmp++; if (err_code !== 2'b01) begin n_bad++; $display("FAIL err_range got %b exp 01", err_code); end
        req(3'd5, 32'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0);
        tick();
        n_cmp++; if (err_code !== 2'b10) begin n_bad++; $display("FAIL err_align got %b exp 10", err_code); end
        req(3'd0, 32'd5, 7'h13, 5'd3, 5'd4, 5'd0, 3'd0);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (err_code !== 2'b11 || err_count !== 8'd3 || err_sticky !== 1'b1) begin n_bad++; $display("FAIL err_illegal got %b %0d %b exp 11 3 1", err_code, err_count, err_sticky); end
        words = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) begin
                words++;
                n_cmp++; if (out_inst !== r[31:0] || out_addr !== 32'd0) begin n_bad++; $display("FAIL err_word got %h @%h exp %h @0", out_inst, out_addr, r[31:0]); end
            end
            tick();
        end
        n_cmp++; if (words !== 1) begin n_bad++; $display("FAIL err_word_count got %0d exp 1", words); end
    endtask

    task automatic test_stall();
        logic [31:0] ew [3];
        logic [33:0] r;
        int idx, got;
        logic acc;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            r = ref_enc(3'd0, 32'(k * 7 + 1), 7'h13, 5'(k + 1), 5'(k + 2), 5'd0, 3'(k));
            ew[k] = r[31:0];
        end
        out_ready = 1'b0; idx = 0;
        for (int c = 0; c < 5; c++) begin
            if (idx < 3) req(3'd0, 32'(idx * 7 + 1), 7'h13, 5'(idx + 1), 5'(idx + 2), 5'd0, 3'(idx));
            else in_valid = 1'b0;
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        n_cmp++; if (idx !== 2) begin n_bad++; $display("FAIL stall_accepts got %0d exp 2", idx); end
        n_cmp++; if (out_valid !== 1'b1 || out_inst !== ew[0] || out_addr !== 32'd0) begin n_bad++; $display("FAIL stall_hold got %b %h @%h exp 1 %h @0", out_valid, out_inst, out_addr, ew[0]); end
        out_ready = 1'b1; got = 0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (idx < 3) req(3'd0, 32'(idx * 7 + 1), 7'h13, 5'(idx + 1), 5'(idx + 2), 5'd0, 3'(idx));
            else in_valid = 1'b0;
            @(negedge clk);
            acc = in_valid && in_ready;
            if (out_valid) begin
                n_cmp++; if (out_inst !== ew[got] || out_addr !== 32'(got * 4)) begin n_bad++; $display("FAIL stall_drain%0d got %h @%h exp %h @%h", got, out_inst, out_addr, ew[got], got * 4); end
                got++;
            end
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        n_cmp++; if (got !== 3) begin n_bad++; $display("FAIL stall_drained got %0d exp 3", got); end
    endtask

    task automatic test_load_base();
        do_reset();
        req(3'd0, 32'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0);
        tick();
        req(3'd0, 32'd2, 7'h13, 5'd2, 5'd2, 5'd0, 3'd0);
        load_base = 1'b1; base_addr = 32'h103;
        tick();
        in_valid = 1'b0; load_base = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_addr !== 32'h100) begin n_bad++; $display("FAIL lb_same got %b @%h exp 1 @100", out_valid, out_addr); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_addr !== 32'h104) begin n_bad++; $display("FAIL lb_next got %b @%h exp 1 @104", out_valid, out_addr); end
        load_base = 1'b1; base_addr = 32'hFFFFFFFC;
        tick();
        load_base = 1'b0;
        req(3'd0, 32'd3, 7'h13, 5'd3, 5'd3, 5'd0, 3'd0);
        tick();
        req(3'd0, 32'd4, 7'h13, 5'd4, 5'd4, 5'd0, 3'd0);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || out_addr !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL lb_top got %b @%h exp 1 @fffffffc", out_valid, out_addr); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_addr !== 32'd0) begin n_bad++; $display("FAIL lb_wrap got %b @%h exp 1 @0", out_valid, out_addr); end
    endtask

    task automatic test_clear_and_rst();
        logic [33:0] r;
        do_reset();
        req(3'd5, 32'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0);
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL clr_pre got %0d exp 1", err_count); end
        req(3'd7, 32'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0);
        tick();
        in_valid = 1'b0; clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        n_cmp++; if (err_count !== 8'd1 || err_sticky !== 1'b1 || err_code !== 2'b11) begin n_bad++; $display("FAIL clr_same got %0d %b %b exp 1 1 11", err_count, err_sticky, err_code); end
        out_ready = 1'b0;
        req(3'd0, 32'd9, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0);
        tick(); tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_pre got %b exp 1", out_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || err_count !== 8'd0 || err_sticky !== 1'b0) begin n_bad++; $display("FAIL rst_mid got %b %0d %b exp 0 0 0", out_valid, err_count, err_sticky); end
        out_ready = 1'b1;
        r = ref_enc(3'd4, 32'h12345000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0);
        req(3'd4, 32'h12345000, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0);
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_addr !== 32'd0 || out_inst !== r[31:0]) begin n_bad++; $display("FAIL rst_after got %b %h @%h exp 1 %h @0", out_valid, out_inst, out_addr, r[31:0]); end
    endtask

    task automatic test_err_saturate();
        do_reset();
        req(3'd6, 32'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0);
        for (int c = 0; c < 260; c++) tick();
        in_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (err_count !== 8'd255 || err_sticky !== 1'b1) begin n_bad++; $display("FAIL err_sat got %0d %b exp 255 1", err_count, err_sticky); end
    endtask

    task automatic test_random();
        logic [31:0] exp_q [$];
        logic [31:0] w, exp_addr, h_inst, h_addr, ri;
        logic [33:0] r;
        logic [2:0] rs;
        logic [1:0] last;
        logic hold;
        int errs, pops;
        do_reset();
        exp_addr = 32'd0; errs = 0; pops = 0; hold = 1'b0; last = 2'd0; h_inst = '0; h_addr = '0;
        for (int c = 0; c < 510; c++) begin
            if (c < 500) begin
                out_ready = $urandom_range(0, 3) != 0;
                rs = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
                ri = $urandom;
                if ($urandom_range(0, 4) != 0)
                    case (rs)
                        3'd0, 3'd1: ri = $urandom_range(0, 4095) - 2048;
                        3'd2: ri = ($urandom_range(0, 4095) - 2048) * 2;
                        3'd3: ri = ($urandom_range(0, 1048575) - 524288) * 2;
                        3'd4: ri = $urandom & 32'hFFFFF000;
                        default: ri = $urandom;
                    endcase
                req(rs, ri, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom));
                in_valid = $urandom_range(0, 4) != 0;
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            @(negedge clk);
            if (hold) begin
                n_cmp++; if (out_valid !== 1'b1 || out_inst !== h_inst || out_addr !== h_addr) begin n_bad++; $display("FAIL rnd_hold got %b %h @%h exp 1 %h @%h", out_valid, out_inst, out_addr, h_inst, h_addr); end
            end
            hold = out_valid && !out_ready; h_inst = out_inst; h_addr = out_addr;
            if (out_valid && out_ready) begin
                pops++;
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL rnd_extra got %h @%h exp none", out_inst, out_addr); end
                else begin
                    w = exp_q.pop_front();
                    if (out_inst !== w || out_addr !== exp_addr) begin n_bad++; $display("FAIL rnd_word got %h @%h exp %h @%h", out_inst, out_addr, w, exp_addr); end
                    exp_addr += 32'd4;
                end
            end
            if (in_valid && in_ready) begin
                r = ref_enc(imm_src, imm, opcode, rd, rs1, rs2, funct3);
                if (r[33:32] != 2'd0) begin errs++; last = r[33:32]; end
                else exp_q.push_back(r[31:0]);
            end
            tick();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rnd_left got %0d exp 0", exp_q.size()); end
        n_cmp++; if (err_count !== 8'((errs > 255) ? 255 : errs) || err_code !== last || err_sticky !== (errs > 0)) begin n_bad++; $display("FAIL rnd_err got %0d %b %b exp %0d %b", err_count, err_code, err_sticky, errs, last); end
        n_cmp++; if (word_count !== 16'(pops)) begin n_bad++; $display("FAIL rnd_wc got %0d exp %0d", word_count, pops); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_errors();
        test_stall();
        test_load_base();
        test_clear_and_rst();
        test_err_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_imm_encoder.md
Name: instr_imm_encoder

Overview:
- Inverse of the decode-side immediate extender. Takes an instruction format select, a 32-bit signed immediate and register/function fields, and packs them into a 32-bit RV32I instruction word.
- Range- and alignment-checks each immediate and drops illegal requests with an error flag.
- Two-stage valid/ready pipeline. Emits (address, word) pairs for the instruction-memory preload path used by the boot/self-test loader.

Parameters:
- ERR_CNT_W, 8, width of the saturating dropped-request counter.
- WORD_CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- imm_src  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U; 101..111 illegal.
- imm  in  32  signed immediate or byte offset.
- opcode  in  7  bits [6:0].
- rd  in  5  destination register (I/J/U).
- rs1  in  5  source register 1 (I/S/B).
- rs2  in  5  source register 2 (S/B).
- funct3  in  3  function field (I/S/B).
- load_base  in  1  load the address counter.
- base_addr  in  32  new base; bits [1:0] are ignored and forced to 0.
- clear_err  in  1  clear the error state.
- out_valid  out  1  word valid.
- out_ready  in  1  sink accepts the word.
- out_inst  out  32  encoded instruction.
- out_addr  out  32  word address for out_inst.
- err_sticky  out  1  set when any request has been dropped.
- err_code  out  2  last drop cause: 01 range, 10 alignment, 11 illegal imm_src.
- err_count  out  ERR_CNT_W  number of dropped requests, saturating.
- word_count  out  WORD_CNT_W  words handed off (out_valid && out_ready), wrapping.

Behaviour:
- Reset: all outputs 0, both stages empty, address counter 0. in_ready = 1 in the cycle after reset.
- Encoding:
  - I: inst[31:20]=imm[11:0], [19:15]=rs1, [14:12]=funct3, [11:7]=rd, [6:0]=opcode.
  - S: [31:25]=imm[11:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=funct3, [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12], [11:7]=rd.
  - U: [31:12]=imm[31:12], [11:7]=rd.
- Legality:
  - Range: I/S need -2048..2047. B needs -4096..4095. J needs -1048576..1048575. Out of range gives code 01.
  - Alignment: B/J need imm[0]=0. U needs imm[11:0]=0. Violation gives code 10.
  - If both range and alignment fail, code 01 wins.
- Stage 1 (S1) registers the encoded word and the legality result on accept.
- Stage 2 (S2) is the output register.
- Handshake:
  - s2_free = !out_valid || out_ready.
  - s1_move = s1_valid && (s1_err || s2_free).
  - in_ready = !s1_valid || s1_move.
  - Full throughput. Latency is 2 cycles from accept to out_valid when out_ready is held high.
  - out_inst and out_addr stay stable while out_valid && !out_ready.
- Errored entries retire from S1 without entering S2:
  - err_sticky is set, err_code is updated, err_count increments and saturates at all-ones.
  - The address counter does not advance.
- Legal entry into S2: out_addr takes the counter value, and the counter advances by 4. The counter wraps 0xFFFFFFFC -> 0.
- load_base:
  - Without a simultaneous S2 entry, the counter becomes base_addr.
  - With a simultaneous S2 entry, the entering word takes base_addr and the counter becomes base_addr+4.
  - Words already in S1 or S2 keep their addresses.
- clear_err zeroes err_sticky, err_code and err_count. If an error retires in the same cycle, the result is sticky=1, count=1, code=new code.
- rst mid-operation: the next cycle shows an empty pipeline and zero outputs. Any in-flight word is lost.

Decomposition:
- Shared package:
  - IMM_I/S/B/J/U codes, matching the decode-side ImmSrc encoding.
  - ERR_NONE/RANGE/ALIGN/ILLEGAL constants.
  - Range limit constants.
- Sub-module imm_pack: combinational format packing plus legality check (imm_src, imm, fields -> inst, err, code). The top level holds the pipeline, counters and error state.

Test Plan:
- I-type, imm=-1, opcode=0010011, rd=1, rs1=2, funct3=0 (addi x1,x2,-1), out_ready=1 -> 2 cycles after accept: out_inst=0xFFF10093, out_addr=0, then word_count=1.
- B-type, imm=-4, rs1=1, rs2=2, funct3=0, opcode=1100011, then J-type, imm=2048, rd=0, opcode=1101111, back-to-back -> out_inst 0xFE208EE3 then 0x0010006F, out_addr 0 then 4, no bubble.
- Requests in order: B with imm=4096, then J with imm=3, then imm_src=101, then a legal I -> error causes range, alignment, illegal; err_count=3, err_code=11, err_sticky=1. Only the I word is emitted, at out_addr=0.
- out_ready=0 for 5 cycles with 3 requests offered -> in_ready drops after 2 accepts, out_inst and out_addr are held. Releasing out_ready drains 3 words in order, addresses 0,4,8.
- load_base with base_addr=0x103, asserted in the same cycle a word enters S2 -> that word gets out_addr=0x100 and the next word gets 0x104. Counter preset to 0xFFFFFFFC -> the following two words get 0xFFFFFFFC then 0.
- clear_err in the same cycle an illegal request retires -> err_count=1, err_sticky=1. rst asserted with S1 and S2 full -> next cycle out_valid=0, err_count=0, next word at address 0.
